// File: rtl/sad_pkg.sv
// sad_pkg: shared FSM state type, latency limit and accumulator width helper for sad_engine.
package sad_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sad_state_t;
  localparam int RD_LAT_MAX = 2;
  function automatic int acc_width(input int pix_w, input int npix);
    return pix_w + $clog2(npix);
  endfunction
endpackage

// File: rtl/sad_absdiff.sv
// sad_absdiff: registered unsigned absolute difference of two pixels.
module sad_absdiff #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             Mrst,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] d
);
  logic [PIX_W-1:0] d_d, d_q;
  always_comb d_d = a >= b ? a - b : b - a;
  always_ff @(posedge clk) begin
    if (Mrst) d_q <= '0;
    else d_q <= d_d;
  end
  assign d = d_q;
endmodule

// File: rtl/sad_engine.sv
// sad_engine: SAD over NPIX pixel pairs; define SAD_MIN_TRACK_EN for best-candidate tracking.
module sad_engine
  import sad_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int NPIX   = 256,
  parameter int RD_LAT = 1,
  parameter int IDX_W  = 8,
  localparam int ADDR_W = NPIX > 1 ? $clog2(NPIX) : 1,
  localparam int ACC_W  = acc_width(PIX_W, NPIX)
) (
  input  logic              clk,
  input  logic              Mrst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  input  logic [PIX_W-1:0]  a_data,
  input  logic [PIX_W-1:0]  b_data,
  output logic [ACC_W-1:0]  sad
`ifdef SAD_MIN_TRACK_EN
  ,
  input  logic              clr_best,
  output logic              best_valid,
  output logic [ACC_W-1:0]  best_sad,
  output logic [IDX_W-1:0]  best_idx
`endif
);
  if (RD_LAT < 0 || RD_LAT > RD_LAT_MAX || NPIX < 1 || IDX_W < 1) begin : g_bad_cfg
    $error("sad_engine: parameter out of range");
  end
  sad_state_t        state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [1:0]        cnt_d, cnt_q;
  logic [ACC_W-1:0]  acc_d, acc_q, sad_d, sad_q;
  logic [RD_LAT:0]   vld_d, vld_q;
  logic [PIX_W-1:0]  diff;
  sad_absdiff #(.PIX_W(PIX_W)) u_absdiff (
    .clk (clk),
    .Mrst(Mrst),
    .a   (a_data),
    .b   (b_data),
    .d   (diff)
  );
  // vld_q[RD_LAT] marks that diff holds a pixel pair issued while rd_en was high
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = rd_en;
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    acc_d   = vld_q[RD_LAT] ? acc_q + ACC_W'(diff) : acc_q;
    sad_d   = sad_q;
    case (state_q)
      IDLE: begin
        state_d = go ? RUN : IDLE;
        addr_d  = go ? '0 : addr_q;
        acc_d   = go ? '0 : acc_d;
      end
      RUN: begin
        state_d = addr_q == ADDR_W'(NPIX - 1) ? DRAIN : RUN;
        addr_d  = addr_q == ADDR_W'(NPIX - 1) ? addr_q : addr_q + 1'b1;
        cnt_d   = '0;
      end
      DRAIN: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == 2'(RD_LAT) ? DONE : DRAIN;
        sad_d   = cnt_q == 2'(RD_LAT) ? acc_d : sad_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Mrst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sad_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sad_q   <= sad_d;
      vld_q   <= vld_d;
    end
  end
  assign busy  = state_q != IDLE;
  assign done  = state_q == DONE;
  assign rd_en = state_q == RUN;
  assign addr  = addr_q;
  assign sad   = sad_q;
`ifdef SAD_MIN_TRACK_EN
  logic             bv_d, bv_q, upd;
  logic [ACC_W-1:0] bs_d, bs_q;
  logic [IDX_W-1:0] bi_d, bi_q, ridx_d, ridx_q;
  // strict less-than keeps the earlier candidate on ties
  always_comb begin
    upd    = done && (!bv_q || sad_q < bs_q);
    bv_d   = !clr_best && (bv_q || upd);
    bs_d   = clr_best ? '0 : upd ? sad_q : bs_q;
    bi_d   = clr_best ? '0 : upd ? ridx_q : bi_q;
    ridx_d = clr_best ? '0 : done ? ridx_q + 1'b1 : ridx_q;
  end
  always_ff @(posedge clk) begin
    if (Mrst) begin
      bv_q   <= 1'b0;
      bs_q   <= '0;
      bi_q   <= '0;
      ridx_q <= '0;
    end else begin
      bv_q   <= bv_d;
      bs_q   <= bs_d;
      bi_q   <= bi_d;
      ridx_q <= ridx_d;
    end
  end
  assign best_valid = bv_q;
  assign best_sad   = bs_q;
  assign best_idx   = bi_q;
`endif
endmodule

// File: tb/tb_sad_engine.sv
// tb_sad_engine: four sad_engine configurations against a plain-arithmetic SAD model.
module tb_sad_engine;
  logic clk = 0;
  always #5 clk = ~clk;
  logic Mrst, go, clr_best;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  int checks = 0, errors = 0;
  localparam int NP [4] = '{4, 4, 4, 256};
  localparam int LT [4] = '{1, 0, 2, 1};
  logic [1:0] addr1, addr0, addr2, ad1_q, ad2_q, ad2_qq;
  logic [7:0] addr256, ad256_q;
  logic       rd1, rd0, rd2, rd256;
  logic [9:0] sad1, sad0, sad2;
  logic [15:0] sad256;
  logic [15:0] sad_w [4];
  logic done_w [4], busy_w [4];
  always @(posedge clk) begin
    ad1_q   <= addr1;
    ad2_q   <= addr2;
    ad2_qq  <= ad2_q;
    ad256_q <= addr256;
  end
`ifdef SAD_MIN_TRACK_EN
  logic bv1, bv0, bv2, bv256;
  logic [9:0] bs1, bs0, bs2;
  logic [15:0] bs256;
  logic [7:0] bi1, bi0, bi2, bi256;
`define TRK(v, s, i) , .clr_best(clr_best), .best_valid(v), .best_sad(s), .best_idx(i)
`else
`define TRK(v, s, i)
`endif
  sad_engine #(.PIX_W(8), .NPIX(4), .RD_LAT(1)) u1 (.clk(clk), .Mrst(Mrst), .go(go),
    .busy(busy_w[0]), .done(done_w[0]), .addr(addr1), .rd_en(rd1),
    .a_data(mem_a[ad1_q]), .b_data(mem_b[ad1_q]), .sad(sad1) `TRK(bv1, bs1, bi1));
  sad_engine #(.PIX_W(8), .NPIX(4), .RD_LAT(0)) u0 (.clk(clk), .Mrst(Mrst), .go(go),
    .busy(busy_w[1]), .done(done_w[1]), .addr(addr0), .rd_en(rd0),
    .a_data(mem_a[addr0]), .b_data(mem_b[addr0]), .sad(sad0) `TRK(bv0, bs0, bi0));
  sad_engine #(.PIX_W(8), .NPIX(4), .RD_LAT(2)) u2 (.clk(clk), .Mrst(Mrst), .go(go),
    .busy(busy_w[2]), .done(done_w[2]), .addr(addr2), .rd_en(rd2),
    .a_data(mem_a[ad2_qq]), .b_data(mem_b[ad2_qq]), .sad(sad2) `TRK(bv2, bs2, bi2));
  sad_engine #(.PIX_W(8), .NPIX(256), .RD_LAT(1)) u256 (.clk(clk), .Mrst(Mrst), .go(go),
    .busy(busy_w[3]), .done(done_w[3]), .addr(addr256), .rd_en(rd256),
    .a_data(mem_a[ad256_q]), .b_data(mem_b[ad256_q]), .sad(sad256) `TRK(bv256, bs256, bi256));
  assign sad_w[0] = {6'b0, sad1};
  assign sad_w[1] = {6'b0, sad0};
  assign sad_w[2] = {6'b0, sad2};
  assign sad_w[3] = sad256;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_sad(input int n);
    int s = 0;
    for (int k = 0; k < n; k++) begin
      int df = int'(mem_a[k]) - int'(mem_b[k]);
      s += df < 0 ? -df : df;
    end
    return s;
  endfunction

  // pulse go; optionally pulse go again at cycle `extra` (must be ignored)
  task automatic run(input string tag, input int extra);
    int lat [4];
    int bc [4];
    int dc [4];
    logic [15:0] s [4];
    for (int i = 0; i < 4; i++) begin
      lat[i] = -1; bc[i] = 0; dc[i] = 0; s[i] = 'x;
    end
    go = 1;
    @(negedge clk);
    go = 0;
    for (int c = 1; c <= 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (busy_w[i]) bc[i]++;
        if (done_w[i]) begin
          dc[i]++;
          if (lat[i] < 0) begin lat[i] = c; s[i] = sad_w[i]; end
        end
      end
      go = (c == extra);
      @(negedge clk);
    end
    go = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_sad%0d", tag, i), 32'(s[i]), 32'(exp_sad(NP[i])));
      chk($sformatf("%s_lat%0d", tag, i), 32'(lat[i]), 32'(NP[i] + LT[i] + 2));
      chk($sformatf("%s_busy%0d", tag, i), 32'(bc[i]), 32'(NP[i] + LT[i] + 2));
      chk($sformatf("%s_ndone%0d", tag, i), 32'(dc[i]), 32'd1);
    end
  endtask

  initial begin
    int first [3];
    int second [3];
    int dcount;
    Mrst = 1; go = 1; clr_best = 0;
    for (int k = 0; k < 256; k++) begin mem_a[k] = 0; mem_b[k] = 0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 0);
      chk($sformatf("rst_done%0d", i), 32'(done_w[i]), 0);
      chk($sformatf("rst_sad%0d", i), 32'(sad_w[i]), 0);
    end
    chk("rst_rd_en", 32'(rd1), 0);
    chk("rst_addr", 32'(addr256), 0);
    go = 0; Mrst = 0;
    @(negedge clk);
    mem_a[0] = 10; mem_a[1] = 0; mem_a[2] = 255; mem_a[3] = 7;
    mem_b[0] = 3;  mem_b[1] = 5; mem_b[2] = 0;   mem_b[3] = 7;
    chk("directed_model", 32'(exp_sad(4)), 32'd267);
    run("directed", 3);
    for (int k = 0; k < 256; k++) begin mem_a[k] = 255; mem_b[k] = 0; end
    run("full", 0);
    chk("full_sad256", 32'(sad256), 32'd65280);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 256; k++) begin
        mem_a[k] = 8'($urandom_range(0, 255));
        mem_b[k] = 8'($urandom_range(0, 255));
      end
      run($sformatf("rnd%0d", r), r + 2);
    end
    // go held high: consecutive runs one IDLE cycle apart
    for (int i = 0; i < 3; i++) begin first[i] = -1; second[i] = -1; end
    go = 1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (done_w[i]) begin
          if (first[i] < 0) first[i] = c;
          else if (second[i] < 0) second[i] = c;
        end
    end
    go = 0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("held_period%0d", i), 32'(second[i] - first[i]), 32'(NP[i] + LT[i] + 3));
    repeat (300) @(negedge clk);
    // reset in the middle of a run
    go = 1;
    @(negedge clk);
    go = 0;
    repeat (2) @(negedge clk);
    Mrst = 1; go = 1;
    @(negedge clk);
    Mrst = 0; go = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_busy%0d", i), 32'(busy_w[i]), 0);
      chk($sformatf("abort_sad%0d", i), 32'(sad_w[i]), 0);
    end
    dcount = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (done_w[i] || busy_w[i]) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 0);
`ifdef SAD_MIN_TRACK_EN
    clr_best = 1;
    @(negedge clk);
    clr_best = 0;
    chk("trk_clr0", 32'(bv1), 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 256; k++) begin mem_a[k] = 0; mem_b[k] = 0; end
      mem_a[0] = r == 0 ? 8'd50 : r == 3 ? 8'd30 : 8'd20;
      run($sformatf("trk%0d", r), 0);
    end
    chk("trk_valid", 32'(bv1), 1);
    chk("trk_best_sad", 32'(bs1), 20);
    chk("trk_best_idx", 32'(bi1), 1);
    chk("trk_best_sad256", 32'(bs256), 20);
    clr_best = 1;
    @(negedge clk);
    clr_best = 0;
    chk("trk_clr_valid", 32'(bv1), 0);
    chk("trk_clr_sad", 32'(bs1), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
